tag_seq_ctrl: RTL
=================

# tag_seq_ctrl

Sequencer for the tag transmit/receive tone generator (tag_rx / mtx_sig family). It resets the generator, then drives its phase AXI-stream handshake through a programmed number of symbols, each held for a programmed number of accepted beats. It exports the current symbol index, frame-boundary `phase_tlast`, status strobes and a front-panel GPIO debug word. It sits between the control register bank and the generator.

## Interface
- `PHASE_WIDTH`, 24: generator phase width; informational, carried for consistency with the generator.
- `NSYMB_WIDTH`, 16: width of symbol index and symbol-count config.
- `NSYMB`, 64: default symbols per frame when `num_symb` = 0.
- `DWELL_WIDTH`, 16: width of per-symbol beat count.
- `GPIO_WIDTH`, 8: front-panel GPIO word width (≥ 4).
- `SRST_CYCLES`, 2: generator `srst` pulse length, 1..15.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a frame.
- `abort` in 1: stop immediately.
- `loop_en` in 1: restart frame automatically after the last symbol.
- `num_symb` in NSYMB_WIDTH: symbols per frame, sampled at start; 0 means NSYMB.
- `dwell_len` in DWELL_WIDTH: beats per symbol, sampled at start; 0 means 1.
- `srst` out 1: synchronous clear to the generator.
- `phase_tvalid` out 1, `phase_tlast` out 1, `phase_tready` in 1: phase stream to the generator.
- `symbN` out NSYMB_WIDTH: current symbol index.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse per completed frame.
- `gpio_out` out GPIO_WIDTH: debug word.

## Operation
- States: IDLE, CLEAR, RUN, FLUSH.
- IDLE: all outputs 0. `start` latches `num_symb` and `dwell_len` with the zero substitutions, then moves to CLEAR. `start` outside IDLE is ignored.
- CLEAR: `srst`=1 for SRST_CYCLES cycles, counters cleared, then RUN.
- RUN: `phase_tvalid`=1. A beat is accepted when `phase_tvalid & phase_tready`.
  - The dwell counter increments on each accepted beat.
  - On the beat where dwell = dwell_len−1, the dwell counter clears and `symbN` increments.
  - `phase_tlast`=1 exactly while symbN = num_symb−1 and dwell = dwell_len−1.
  - Accepting the tlast beat pulses `done` the next cycle. It then goes to IDLE if `loop_en`=0, or stays in RUN with symbN=0 and no srst if `loop_en`=1.
  - `loop_en` is sampled on the tlast beat.
- `tvalid`/`tlast` are stable while `tready` is low. They are never withdrawn except by `abort`.
- `abort`, in any non-IDLE state:
  - Next cycle enters FLUSH: `phase_tvalid`=0 and `srst`=1 for one cycle.
  - Then IDLE.
  - `done` is not pulsed.
  - If `abort` and `start` arrive together in IDLE, `abort` wins and `start` is dropped.
- Counters never wrap past their configured terminal values. `num_symb` up to 2^NSYMB_WIDTH−1 is legal.
- Reset mid-frame: all state returns to IDLE values asynchronously; the generator sees `srst`=0, `tvalid`=0.

## Timing
- Reset values: `srst`, `phase_tvalid`, `phase_tlast`, `busy`, `done` = 0; `symbN` = 0; `gpio_out` = 0.
- `start` high at edge T:
  - `busy` and `srst` high from T+1 through T+SRST_CYCLES.
  - `phase_tvalid` high from T+SRST_CYCLES+1.
- `symbN` updates the cycle after the accepting edge.
- With `tready` held high, frame length is num_symb×dwell_len beats.
- `done` is high the cycle after the tlast handshake. `busy` falls in that same cycle when not looping.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `TAG_SEQ_GPIO_EN` defined:
  - `gpio_out[0]` = busy.
  - `gpio_out[1]` = one-cycle symbol-boundary strobe.
  - `gpio_out[2]` = frame-start strobe, on the first RUN cycle of each frame.
  - `gpio_out[3]` = `srst`.
  - Upper bits = low bits of `symbN`.
  - All bits are registered.
- Undefined: `gpio_out` tied to 0 and the GPIO registers are not synthesized. All other behaviour is identical.

## Test plan
- Basic frame: num_symb=4, dwell_len=3, `tready`=1, `start` pulse.
  - `srst` high for 2 cycles.
  - 12 beats; symbN steps 0,1,2,3 every 3 beats.
  - `tlast` on beat 12 only; one `done`; IDLE.
- Backpressure: num_symb=2, dwell_len=2, `tready` toggling 1010….
  - `tvalid`/`tlast` stable during stalls; exactly 4 accepted beats; `done` after the 4th.
- Zero config: num_symb=0, dwell_len=0.
  - 64 beats, symbN 0..63, `tlast` at symbN=63.
- Loop: `loop_en`=1, num_symb=3, dwell_len=1.
  - `done` every 3 beats; symbN wraps 2→0 with no `srst`.
  - Dropping `loop_en` ends at the next tlast.
- Abort at symbN=5: `tvalid` low next cycle, one-cycle `srst`, IDLE, no `done`. Simultaneous `start`+`abort` in IDLE → stays IDLE.
- Async reset asserted mid-RUN: all outputs 0 immediately. A fresh `start` after release produces a full clean frame. With `TAG_SEQ_GPIO_EN`, check `gpio_out[1]` pulses exactly num_symb times per frame.

Source files
------------

// File: rtl/tag_seq_ctrl_if.sv
// rtl/tag_seq_ctrl_if.sv - phase stream handshake between tag_seq_ctrl and the tone generator
// Purpose: bundles the phase AXI-stream-like handshake.
// Signals:
//   phase_tvalid - sequencer has a phase beat pending
//   phase_tlast  - pending beat is the last beat of the frame
//   phase_tready - generator accepts the pending beat
// Modports: master (sequencer side), slave (generator side).
interface tag_seq_ctrl_if;
  logic phase_tvalid;
  logic phase_tlast;
  logic phase_tready;

  modport master (output phase_tvalid, output phase_tlast, input phase_tready);
  modport slave  (input phase_tvalid, input phase_tlast, output phase_tready);
endinterface

// File: rtl/tag_seq_ctrl.sv
// rtl/tag_seq_ctrl.sv - frame sequencer driving the tag tone generator phase stream
// Purpose: resets the generator, then walks num_symb symbols of dwell_len accepted
//   beats each on the phase stream, with optional looping, abort and debug GPIO.
// Ports:
//   clk, reset (async, active-low)
//   start, abort, loop_en        - control strobes/levels
//   num_symb, dwell_len          - frame config, sampled on start (0 -> NSYMB / 1)
//   srst                         - synchronous clear to the generator
//   phase (tag_seq_ctrl_if.master) - phase_tvalid/phase_tlast out, phase_tready in
//   symbN, busy, done            - status
//   gpio_out                     - debug word, only populated with TAG_SEQ_GPIO_EN defined
// Optional feature macro: TAG_SEQ_GPIO_EN
module tag_seq_ctrl #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int NSYMB       = 64,
  parameter int DWELL_WIDTH = 16,
  parameter int GPIO_WIDTH  = 8,
  parameter int SRST_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop_en,
  input  logic [NSYMB_WIDTH-1:0] num_symb,
  input  logic [DWELL_WIDTH-1:0] dwell_len,
  output logic                   srst,
  tag_seq_ctrl_if.master         phase,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic                   busy,
  output logic                   done,
  output logic [GPIO_WIDTH-1:0]  gpio_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [NSYMB_WIDTH-1:0] NSYMB_ONE = NSYMB_WIDTH'(1);
  localparam logic [NSYMB_WIDTH-1:0] NSYMB_DEF = NSYMB_WIDTH'(NSYMB);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);
  localparam logic [3:0]             CLR_LAST  = 4'(SRST_CYCLES - 1);

  if (PHASE_WIDTH < 1 || SRST_CYCLES < 1 || SRST_CYCLES > 15 || GPIO_WIDTH < 4) begin : g_bad_param
    $error("tag_seq_ctrl: illegal parameter combination");
  end

  logic [1:0]             state_q, state_d;
  logic [NSYMB_WIDTH-1:0] ncfg_q, ncfg_d;
  logic [DWELL_WIDTH-1:0] dcfg_q, dcfg_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [3:0]             clr_cnt_q, clr_cnt_d;
  logic                   srst_q, tvalid_q, tlast_q, busy_q, done_q;
  logic                   srst_d, tlast_d, done_d, accept, last_dwell, last_symb;

  assign accept     = tvalid_q & phase.phase_tready;
  assign last_dwell = (dwell_q == dcfg_q - DWELL_ONE);
  assign last_symb  = (symb_q == ncfg_q - NSYMB_ONE);

  always_comb begin
    state_d   = state_q;
    ncfg_d    = ncfg_q;
    dcfg_d    = dcfg_q;
    symb_d    = symb_q;
    dwell_d   = dwell_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort has priority, so a coincident start is simply dropped
        if (start && !abort) begin
          ncfg_d    = (num_symb == '0) ? NSYMB_DEF : num_symb;
          dcfg_d    = (dwell_len == '0) ? DWELL_ONE : dwell_len;
          symb_d    = '0;
          dwell_d   = '0;
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_FLUSH;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        if (abort) begin
          symb_d  = '0;
          dwell_d = '0;
          state_d = S_FLUSH;
        end else if (accept) begin
          if (last_dwell) begin
            dwell_d = '0;
            if (last_symb) begin
              symb_d = '0;
              done_d = 1'b1;
              // looping restarts straight into RUN without another generator clear
              if (!loop_en) state_d = S_IDLE;
            end else begin
              symb_d = symb_q + NSYMB_ONE;
            end
          end else begin
            dwell_d = dwell_q + DWELL_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are registered from next-state values so they line up with the state
  assign srst_d  = (state_d == S_CLEAR) || (state_d == S_FLUSH);
  assign tlast_d = (state_d == S_RUN) && (symb_d == ncfg_d - NSYMB_ONE) &&
                   (dwell_d == dcfg_d - DWELL_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ncfg_q    <= NSYMB_DEF;
      dcfg_q    <= DWELL_ONE;
      symb_q    <= '0;
      dwell_q   <= '0;
      clr_cnt_q <= '0;
      srst_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ncfg_q    <= ncfg_d;
      dcfg_q    <= dcfg_d;
      symb_q    <= symb_d;
      dwell_q   <= dwell_d;
      clr_cnt_q <= clr_cnt_d;
      srst_q    <= srst_d;
      tvalid_q  <= (state_d == S_RUN);
      tlast_q   <= tlast_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
    end
  end

  assign srst               = srst_q;
  assign phase.phase_tvalid = tvalid_q;
  assign phase.phase_tlast  = tlast_q;
  assign symbN              = symb_q;
  assign busy               = busy_q;
  assign done               = done_q;

`ifdef TAG_SEQ_GPIO_EN
  localparam int GSYM = (GPIO_WIDTH - 4 < NSYMB_WIDTH) ? GPIO_WIDTH - 4 : NSYMB_WIDTH;

  logic [GPIO_WIDTH-1:0] gpio_q, gpio_d;
  logic                  sym_stb, frame_stb;

  assign sym_stb   = (state_q == S_RUN) && !abort && accept && last_dwell;
  // first RUN cycle: leaving CLEAR, or wrapping in loop mode
  assign frame_stb = ((state_q == S_CLEAR) && (state_d == S_RUN)) ||
                     (done_d && (state_d == S_RUN));

  always_comb begin
    gpio_d    = '0;
    gpio_d[0] = (state_d != S_IDLE);
    gpio_d[1] = sym_stb;
    gpio_d[2] = frame_stb;
    gpio_d[3] = srst_d;
    for (int i = 0; i < GSYM; i++) gpio_d[i+4] = symb_d[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gpio_q <= '0;
    else        gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;
`else
  assign gpio_out = '0;
`endif

endmodule
